turn_sequencer: RTL

Turn sequencer and move arbiter for the tic-tac-toe game. It owns the 3x3 board and alternates exclusive board access between the human player and the computer AI. It validates each move and detects win, draw and AI forfeit. It sits between the player input path, the computerAi move generator and the display logic.

---
 rtl/turn_sequencer_pkg.sv | 58 +++++
 rtl/turn_sequencer_if.sv | 26 ++
 rtl/turn_sequencer_win_checker.sv | 24 ++
 rtl/turn_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared tic-tac-toe types: cell codes, sequencer states, the eight win lines
// and small board-access helpers.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    AI    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    P1_WAIT,
    AI_REQ,
    AI_WAIT,
    EVAL,
    DONE
  } state_t;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;

  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Out-of-range indices read as EMPTY; legality checks the range separately.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = EMPTY;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) r = b[2*i +: 2];
    end
    return r;
  endfunction

  function automatic logic move_legal(input logic [17:0] b, input logic [3:0] idx);
    return (idx <= 4'd8) && (cell_at(b, idx) == EMPTY);
  endfunction

  function automatic logic [17:0] place_mark(input logic [17:0] b, input logic [3:0] idx,
                                             input cell_t mark);
    logic [17:0] r;
    r = b;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) r[2*i +: 2] = mark;
    end
    return r;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Game-control bundle between the player/AI move sources and the turn sequencer.
interface turn_sequencer_if;
  logic        start;
  logic        p1_valid;
  logic [3:0]  p1_cell;
  logic        p1_ready;
  logic        ai_req;
  logic        ai_valid;
  logic [3:0]  ai_cell;
  logic        ai_ready;
  logic [17:0] board;
  logic [3:0]  move_count;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output start, p1_valid, p1_cell, ai_valid, ai_cell,
    input  p1_ready, ai_req, ai_ready, board, move_count, illegal, game_over, winner
  );

  modport slave (
    input  start, p1_valid, p1_cell, ai_valid, ai_cell,
    output p1_ready, ai_req, ai_ready, board, move_count, illegal, game_over, winner
  );
endinterface

// File: rtl/turn_sequencer_win_checker.sv
// Combinational three-in-a-row detector over the packed 18-bit board.
module win_checker
  import tictactoe_pkg::*;
(
  input  logic [17:0] board,
  output logic        win,
  output logic [1:0]  win_code
);

  always_comb begin
    win      = 1'b0;
    win_code = EMPTY;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (!win
          && cell_at(board, WIN_LINES[i][0]) != EMPTY
          && cell_at(board, WIN_LINES[i][0]) == cell_at(board, WIN_LINES[i][1])
          && cell_at(board, WIN_LINES[i][1]) == cell_at(board, WIN_LINES[i][2])) begin
        win      = 1'b1;
        win_code = cell_at(board, WIN_LINES[i][0]);
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Owns the board, alternates move access between player 1 and the AI,
// validates moves and declares win, draw or AI forfeit.
module turn_sequencer
  import tictactoe_pkg::*;
#(
  parameter int unsigned AI_TIMEOUT   = 64,
  parameter bit          FIRST_PLAYER = 1'b0
) (
  input logic             clk,
  input logic             reset,
  turn_sequencer_if.slave bus
);

  localparam logic [7:0] TIMEOUT_LOAD = 8'(AI_TIMEOUT);
  localparam state_t     FIRST_STATE  = FIRST_PLAYER ? AI_REQ : P1_WAIT;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  timer_q, timer_d;

  logic        win;
  logic [1:0]  win_code;

  win_checker u_win_checker (
    .board    (board_q),
    .win      (win),
    .win_code (win_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      board_q   <= '0;
      count_q   <= '0;
      winner_q  <= EMPTY;
      illegal_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      count_q   <= count_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    count_d   = count_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
    timer_d   = timer_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          board_d  = '0;
          count_d  = '0;
          winner_d = EMPTY;
          state_d  = FIRST_STATE;
        end
      end

      P1_WAIT: begin
        if (bus.p1_valid) begin
          if (move_legal(board_q, bus.p1_cell)) begin
            board_d = place_mark(board_q, bus.p1_cell, P1);
            count_d = count_q + 4'd1;
            state_d = EVAL;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      AI_REQ: begin
        timer_d = TIMEOUT_LOAD;
        state_d = AI_WAIT;
      end

      // The AI sees ai_ready for exactly AI_TIMEOUT cycles; the forfeit is
      // taken on the edge where the counter would reach zero.
      AI_WAIT: begin
        timer_d = timer_q - 8'd1;
        if (bus.ai_valid) begin
          if (move_legal(board_q, bus.ai_cell)) begin
            board_d = place_mark(board_q, bus.ai_cell, AI);
            count_d = count_q + 4'd1;
            state_d = EVAL;
          end else begin
            illegal_d = 1'b1;
            state_d   = AI_REQ;
          end
        end else if (timer_q <= 8'd1) begin
          winner_d = P1;
          state_d  = DONE;
        end
      end

      // Move parity tells who just played: odd counts belong to the first mover.
      EVAL: begin
        if (win) begin
          winner_d = win_code;
          state_d  = DONE;
        end else if (count_q == 4'd9) begin
          winner_d = EMPTY;
          state_d  = DONE;
        end else if (count_q[0] ^ FIRST_PLAYER) begin
          state_d = AI_REQ;
        end else begin
          state_d = P1_WAIT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.p1_ready   = (state_q == P1_WAIT);
  assign bus.ai_ready   = (state_q == AI_WAIT);
  assign bus.ai_req     = (state_q == AI_REQ);
  assign bus.game_over  = (state_q == DONE);
  assign bus.illegal    = illegal_q;
  assign bus.board      = board_q;
  assign bus.move_count = count_q;
  assign bus.winner     = winner_q;

endmodule
